// File: rtl/alu_result_skid.sv
// rtl/alu_result_skid.sv - registered ALU result stage with 2-entry skid buffer and flush
//
// Captures each accepted ALU/shifter result together with its destination
// register and write enable, and presents it to the memory/writeback stage.
// The main entry drives the outputs; the skid entry absorbs one extra result,
// so IN_READY can come from registered state alone and still stream one result
// per cycle.
//
// Optional feature: define ALU_RESULT_SKID_FWD_EN to add the EX-to-EX bypass
// ports FWD_VALID / FWD_DEST / FWD_RESULT, driven combinationally from the
// main entry.
//
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   IN_VALID / IN_READY  upstream handshake
//   IN_RESULT[N-1:0]     ALU/shifter result
//   IN_DEST[M-1:0]       destination register index
//   IN_WE                register write request
//   FLUSH                synchronous squash of every held entry
//   OUT_VALID / OUT_READY downstream handshake
//   OUT_RESULT[N-1:0]    held result
//   OUT_DEST[M-1:0]      held destination
//   OUT_WE               held write enable, already cleared for register 0
//   OUT_ZERO             held result is all zeros
//   FWD_VALID/FWD_DEST/FWD_RESULT  bypass view of the main entry (optional)

module alu_result_skid #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [N-1:0] IN_RESULT,
    input  logic [M-1:0] IN_DEST,
    input  logic         IN_WE,
    input  logic         FLUSH,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [N-1:0] OUT_RESULT,
    output logic [M-1:0] OUT_DEST,
    output logic         OUT_WE,
`ifdef ALU_RESULT_SKID_FWD_EN
    output logic         OUT_ZERO,
    output logic         FWD_VALID,
    output logic [M-1:0] FWD_DEST,
    output logic [N-1:0] FWD_RESULT
`else
    output logic         OUT_ZERO
`endif
);

    // Occupancy encoding: number of valid entries held.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]   state_q,       state_d;

    logic [N-1:0] main_result_q, main_result_d;
    logic [M-1:0] main_dest_q,   main_dest_d;
    logic         main_we_q,     main_we_d;
    logic         main_zero_q,   main_zero_d;

    logic [N-1:0] skid_result_q, skid_result_d;
    logic [M-1:0] skid_dest_q,   skid_dest_d;
    logic         skid_we_q,     skid_we_d;
    logic         skid_zero_q,   skid_zero_d;

    logic         in_fire;
    logic         out_fire;
    logic         cap_we;
    logic         cap_zero;

    // Ready depends only on registered occupancy (and reset), never on OUT_READY.
    assign IN_READY  = (state_q != ST_FULL) & ~RST;
    assign OUT_VALID = (state_q != ST_EMPTY);

    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = OUT_VALID & OUT_READY;

    // A write to register 0 is architecturally a no-op, so it is dropped here
    // once rather than in every consumer.
    assign cap_we    = IN_WE & (IN_DEST != '0);
    assign cap_zero  = (IN_RESULT == '0);

    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_dest_d   = main_dest_q;
        main_we_d     = main_we_q;
        main_zero_d   = main_zero_q;
        skid_result_d = skid_result_q;
        skid_dest_d   = skid_dest_q;
        skid_we_d     = skid_we_q;
        skid_zero_d   = skid_zero_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_result_d = IN_RESULT;
                    main_dest_d   = IN_DEST;
                    main_we_d     = cap_we;
                    main_zero_d   = cap_zero;
                    state_d       = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Current entry leaves as the new one arrives: stream through main.
                    main_result_d = IN_RESULT;
                    main_dest_d   = IN_DEST;
                    main_we_d     = cap_we;
                    main_zero_d   = cap_zero;
                end else if (in_fire) begin
                    // Main is stalled; park the newcomer behind it.
                    skid_result_d = IN_RESULT;
                    skid_dest_d   = IN_DEST;
                    skid_we_d     = cap_we;
                    skid_zero_d   = cap_zero;
                    state_d       = ST_FULL;
                end else if (out_fire) begin
                    state_d       = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // IN_READY is low here, so only a drain can happen.
                if (out_fire) begin
                    main_result_d = skid_result_q;
                    main_dest_d   = skid_dest_q;
                    main_we_d     = skid_we_q;
                    main_zero_d   = skid_zero_q;
                    state_d       = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Squash overrides any transfer: a same-cycle input is discarded and
        // every stored field is cleared so stale data cannot be forwarded.
        if (FLUSH) begin
            state_d       = ST_EMPTY;
            main_result_d = '0;
            main_dest_d   = '0;
            main_we_d     = 1'b0;
            main_zero_d   = 1'b0;
            skid_result_d = '0;
            skid_dest_d   = '0;
            skid_we_d     = 1'b0;
            skid_zero_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_EMPTY;
            main_result_q <= '0;
            main_dest_q   <= '0;
            main_we_q     <= 1'b0;
            main_zero_q   <= 1'b0;
            skid_result_q <= '0;
            skid_dest_q   <= '0;
            skid_we_q     <= 1'b0;
            skid_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            main_result_q <= main_result_d;
            main_dest_q   <= main_dest_d;
            main_we_q     <= main_we_d;
            main_zero_q   <= main_zero_d;
            skid_result_q <= skid_result_d;
            skid_dest_q   <= skid_dest_d;
            skid_we_q     <= skid_we_d;
            skid_zero_q   <= skid_zero_d;
        end
    end

    assign OUT_RESULT = main_result_q;
    assign OUT_DEST   = main_dest_q;
    assign OUT_WE     = main_we_q;
    assign OUT_ZERO   = main_zero_q;

`ifdef ALU_RESULT_SKID_FWD_EN
    // Bypass is only meaningful for an entry that will actually write a register.
    assign FWD_VALID  = OUT_VALID & main_we_q;
    assign FWD_DEST   = main_dest_q;
    assign FWD_RESULT = main_result_q;
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// tb/tb_alu_result_skid.sv - scoreboard bench for alu_result_skid

module tb_alu_result_skid;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_RESULT;
    logic [4:0]  IN_DEST;
    logic        IN_WE;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_RESULT;
    logic [4:0]  OUT_DEST;
    logic        OUT_WE;
    logic        OUT_ZERO;
`ifdef ALU_RESULT_SKID_FWD_EN
    logic        FWD_VALID;
    logic [4:0]  FWD_DEST;
    logic [31:0] FWD_RESULT;
`endif

    alu_result_skid #(.N(32), .M(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_RESULT  (IN_RESULT),
        .IN_DEST    (IN_DEST),
        .IN_WE      (IN_WE),
        .FLUSH      (FLUSH),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_RESULT (OUT_RESULT),
        .OUT_DEST   (OUT_DEST),
        .OUT_WE     (OUT_WE),
`ifdef ALU_RESULT_SKID_FWD_EN
        .OUT_ZERO   (OUT_ZERO),
        .FWD_VALID  (FWD_VALID),
        .FWD_DEST   (FWD_DEST),
        .FWD_RESULT (FWD_RESULT)
`else
        .OUT_ZERO   (OUT_ZERO)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  d;
        logic        w;
        logic        z;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic clr_pending = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected entry built from the architectural rules.
    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] d, input logic w);
        exp_t e;
        e.r = r;
        e.d = d;
        e.w = w && (d != 5'd0);
        e.z = (r == 32'd0);
        return e;
    endfunction

    // One clock cycle of stimulus. Queue size at posedge+2 equals occupancy.
    task automatic cycle(input logic v, input logic [31:0] r, input logic [4:0] d,
                         input logic w, input logic ordy, input logic fl, input logic rs);
        logic fire;
        @(posedge CLK);
        #1;
        IN_VALID  = v;
        IN_RESULT = r;
        IN_DEST   = d;
        IN_WE     = w;
        OUT_READY = rs ? 1'b0 : ordy;
        FLUSH     = fl;
        RST       = rs;
        #1;
        chk("in_ready", {63'd0, IN_READY}, {63'd0, (!rs && sbq.size() < 2)});
        chk("out_valid", {63'd0, OUT_VALID}, {63'd0, (sbq.size() != 0)});
        if (clr_pending) begin
            chk("cleared_fields", {26'd0, OUT_RESULT, OUT_DEST, OUT_WE, OUT_ZERO}, 64'd0);
            clr_pending = 1'b0;
        end
`ifdef ALU_RESULT_SKID_FWD_EN
        if (sbq.size() != 0) begin
            chk("fwd", {25'd0, FWD_VALID, FWD_DEST, FWD_RESULT},
                {25'd0, sbq[0].w, sbq[0].d, sbq[0].r});
        end else begin
            chk("fwd_valid_idle", {63'd0, FWD_VALID}, 64'd0);
        end
`endif
        @(negedge CLK);
        #1;
        fire = v && IN_READY;
        if (rs || fl) begin
            sbq.delete();
            clr_pending = 1'b1;
        end else if (fire) begin
            sbq.push_back(mk(r, d, w));
        end
    endtask

    // Monitor: pops on every output transfer and checks hold stability under stall.
    logic        prev_stall = 1'b0;
    logic [38:0] prev_out   = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (prev_stall) begin
                chk("hold_stable", {25'd0, OUT_RESULT, OUT_DEST, OUT_WE, OUT_ZERO},
                    {25'd0, prev_out});
            end
            prev_stall = (OUT_VALID === 1'b1) && !OUT_READY && !FLUSH && !RST;
            prev_out   = {OUT_RESULT, OUT_DEST, OUT_WE, OUT_ZERO};
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("spurious_output", {63'd0, OUT_VALID}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_entry", {25'd0, OUT_RESULT, OUT_DEST, OUT_WE, OUT_ZERO},
                        {25'd0, e.r, e.d, e.w, e.z});
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        IN_VALID = 1'b0;
        IN_RESULT = '0;
        IN_DEST = '0;
        IN_WE = 1'b0;
        FLUSH = 1'b0;
        OUT_READY = 1'b0;

        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Streaming with OUT_READY=1.
        cycle(1, 32'h0000_0001, 5'd1, 1, 1, 0, 0);
        cycle(1, 32'h8000_0000, 5'd2, 1, 1, 0, 0);
        cycle(1, 32'hFFFF_FFFF, 5'd3, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Backpressure fills the skid, then drains in order.
        cycle(1, 32'hA, 5'd4, 1, 0, 0, 0);
        cycle(1, 32'hB, 5'd4, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("full_holds_a", {32'd0, OUT_RESULT}, 64'hA);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Register-0 write suppression and zero detect.
        cycle(1, 32'h0, 5'd0, 1, 1, 0, 0);
        cycle(1, 32'h10, 5'd5, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Forwarding view of a held entry, then one with WE=0.
        cycle(1, 32'h1234, 5'd7, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(1, 32'h55, 5'd9, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Flush while FULL with a simultaneous input that must be dropped.
        cycle(1, 32'h1, 5'd1, 1, 0, 0, 0);
        cycle(1, 32'h2, 5'd2, 1, 0, 0, 0);
        cycle(1, 32'h77, 5'd3, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Reset while holding one entry.
        cycle(1, 32'hDEAD, 5'd6, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            logic [4:0]  d;
            r = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            d = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), r, d, 1'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        chk("drained", {32'd0, 32'(sbq.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_skid.md
# alu_result_skid

Registered result stage directly downstream of the ALU32 datapath (shifter/logic/arithmetic result mux). It captures each valid 32-bit result with its destination register and write enable, then presents them to the memory/writeback stage. A 2-entry skid buffer provides full throughput under a registered ready/valid handshake. A synchronous flush supports branch mispredict squashing.

## Interface
Parameters:
- N, 32, result data width
- M, 5, destination register index width

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  upstream result valid
- IN_READY  out  1  stage can accept a result this cycle
- IN_RESULT  in  N  ALU/shifter result
- IN_DEST  in  M  destination register index
- IN_WE  in  1  register write request
- FLUSH  in  1  synchronous squash of all held entries
- OUT_VALID  out  1  output entry valid
- OUT_READY  in  1  downstream accepts
- OUT_RESULT  out  N  held result
- OUT_DEST  out  M  held destination
- OUT_WE  out  1  held write enable; already qualified against register 0
- OUT_ZERO  out  1  held result equals 0

## Operation
- Transfer events:
  - in_fire = IN_VALID & IN_READY
  - out_fire = OUT_VALID & OUT_READY
- Storage:
  - main entry drives OUT_*
  - skid entry holds one overflow result
- Occupancy state machine: EMPTY (0), ONE (1), FULL (2).
- Transitions from EMPTY:
  - in_fire: load main, go to ONE
- Transitions from ONE:
  - in_fire & out_fire: load main, stay in ONE
  - in_fire only: load skid, go to FULL
  - out_fire only: go to EMPTY
- Transitions from FULL:
  - out_fire: main <= skid, go to ONE
  - in_fire is impossible in FULL
- Ready and valid decode:
  - IN_READY = (state != FULL) & ~RST
  - OUT_VALID = (state != EMPTY)
- Capture rules, applied on every load from the input:
  - WE field <= IN_WE & (IN_DEST != 0)
  - ZERO field <= (IN_RESULT == 0), computed over all N bits
- Result and dest pass through unmodified; no width conversion.
- Ordering is strictly FIFO; results never reorder or duplicate.
- FLUSH:
  - next state EMPTY; any in_fire in the same cycle is discarded
  - the out_fire in that cycle still counts as consumed downstream
  - all stored fields are cleared to 0
- Priority: RST > FLUSH > normal transfers.
- Reset mid-operation: all entries are dropped. Nothing is delivered after the reset edge.

## Timing
- Latency: an in_fire at edge k makes OUT_VALID=1 with that data after edge k, i.e. 1 cycle.
- Throughput: 1 result per cycle while OUT_READY=1.
- IN_READY is a decode of registered state only; there is no combinational path from OUT_READY. It deasserts the cycle after the skid fills.
- Handshake stability: while OUT_VALID=1 and OUT_READY=0, OUT_RESULT, OUT_DEST, OUT_WE and OUT_ZERO hold stable.
- Reset values, at the edge with RST=1:
  - state EMPTY
  - OUT_VALID=0, OUT_RESULT=0, OUT_DEST=0, OUT_WE=0, OUT_ZERO=0
- IN_READY is 0 while RST is high and 1 in the first cycle after release.
- FLUSH takes effect at the next edge; OUT_VALID=0 in the following cycle.

## Configuration
- Macro: ALU_RESULT_SKID_FWD_EN.
- Defined: three extra output ports exist, all combinational from the main entry.
  - FWD_VALID (1) = OUT_VALID & OUT_WE
  - FWD_DEST (M) = OUT_DEST
  - FWD_RESULT (N) = OUT_RESULT
  - The hazard unit uses these for EX-to-EX bypass. FWD_VALID is 0 during reset and after a flush.
- Undefined: these ports and their logic are absent; everything else is unchanged.

## Test plan
- Streaming:
  - Stimulus: OUT_READY=1; send results 0x00000001, 0x80000000, 0xFFFFFFFF on back-to-back cycles.
  - Response: each appears 1 cycle later in order; IN_READY stays 1.
- Backpressure and skid:
  - Stimulus: OUT_READY=0; send 0xA, then 0xB on consecutive cycles.
  - Response: state FULL and IN_READY=0; OUT_RESULT holds 0xA.
  - Stimulus: raise OUT_READY.
  - Response: 0xA then 0xB are delivered; IN_READY returns to 1 the cycle after 0xA is accepted.
- Register-0 and zero rules:
  - IN_DEST=0, IN_WE=1, IN_RESULT=0 -> OUT_WE=0, OUT_ZERO=1.
  - IN_DEST=5, IN_WE=1, IN_RESULT=0x10 -> OUT_WE=1, OUT_ZERO=0.
- Flush:
  - Stimulus: reach FULL, then assert FLUSH together with IN_VALID=1 and IN_RESULT=0x77.
  - Response: next cycle OUT_VALID=0, IN_READY=1; 0x77 is never output.
- Reset mid-operation:
  - Stimulus: state ONE; assert RST for 1 cycle.
  - Response: all outputs 0, IN_READY=0 during reset and 1 after release; no stale entry is delivered.
- With ALU_RESULT_SKID_FWD_EN:
  - Stimulus: hold an entry with dest 7, WE=1, result 0x1234.
  - Response: FWD_VALID=1, FWD_DEST=7, FWD_RESULT=0x1234.
  - Stimulus: an entry with WE=0.
  - Response: FWD_VALID=0.
